// File: rtl/uart_line_echo_pkg.sv
// Shared definitions for the line-buffered UART echo stage.
// State encodings and the default line terminator.
package uart_line_echo_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [7:0] TERM_DEFAULT = 8'h0D;

endpackage

// File: rtl/uart_line_echo_if.sv
// Byte-level link between uart_rx/uart_tx and the echo stage.
// master = echo stage, slave = UART side.
interface uart_line_echo_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_break;
  logic                    uart_tx_busy;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;

  modport master (
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_break,
    input  uart_tx_busy,
    output uart_tx_en,
    output uart_tx_data
  );

  modport slave (
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_break,
    output uart_tx_busy,
    input  uart_tx_en,
    input  uart_tx_data
  );

endinterface

// File: rtl/uart_line_echo_ram.sv
// Line storage: synchronous write, asynchronous read, no reset.
// Instantiated as uart_line_ram inside uart_line_echo.
module uart_line_ram #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [PAYLOAD_BITS-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [PAYLOAD_BITS-1:0] rdata
);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_echo.sv
// Collects received bytes until a terminator, then replays the
// line to the transmitter, pacing each byte on uart_tx_busy.
module uart_line_echo
  import uart_line_echo_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter logic [PAYLOAD_BITS-1:0] TERM =
    PAYLOAD_BITS'(TERM_DEFAULT),
  localparam int AW          = $clog2(DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic            clk,
  input  logic            resetn,
  uart_line_echo_if.master bus,
  output logic            draining,
  output logic [LW-1:0]   line_len,
  output logic            overflow
);

  state_t state, state_nx;

  logic [AW-1:0]           wr_ptr;
  logic [LW-1:0]           rd_ptr;
  logic [PAYLOAD_BITS-1:0] rdata;

  logic full, is_term, done;
  logic we, clr_fill, clr_all, fire, term_go, drop;

  assign full    = line_len == LW'(DEPTH);
  assign is_term = bus.uart_rx_data == TERM;
  assign done    = rd_ptr == line_len;

  uart_line_ram #(
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .DEPTH       (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(bus.uart_rx_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FILL;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:
        if (!bus.uart_rx_break && bus.uart_rx_valid && is_term)
          state_nx = ISSUE;
      ISSUE:
        if (!bus.uart_tx_busy) state_nx = GAP;
      GAP:
        state_nx = WAIT;
      WAIT:
        if (!bus.uart_tx_busy)
          state_nx = done ? FILL : ISSUE;
    endcase
  end

  // Break wins over a coincident byte; full buffer drops but
  // a dropped terminator still starts the drain.
  always_comb begin
    we       = 1'b0;
    clr_fill = 1'b0;
    clr_all  = 1'b0;
    fire     = 1'b0;
    term_go  = 1'b0;
    drop     = 1'b0;
    unique case (state)
      FILL:
        if (bus.uart_rx_break) begin
          clr_fill = 1'b1;
        end else if (bus.uart_rx_valid) begin
          we      = !full;
          drop    = full;
          term_go = is_term;
        end
      ISSUE: fire = !bus.uart_tx_busy;
      GAP:   ;
      WAIT:  clr_all = !bus.uart_tx_busy && done;
    endcase
    if (state != FILL && bus.uart_rx_valid) drop = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      line_len         <= '0;
      overflow         <= 1'b0;
    end else begin
      bus.uart_tx_en <= fire;
      if (fire) begin
        bus.uart_tx_data <= rdata;
        rd_ptr           <= rd_ptr + LW'(1);
      end
      if (we) begin
        wr_ptr   <= wr_ptr + AW'(1);
        line_len <= line_len + LW'(1);
      end
      if (clr_fill) begin
        wr_ptr   <= '0;
        line_len <= '0;
      end
      if (term_go) rd_ptr <= '0;
      if (clr_all) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        line_len <= '0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign draining = state != FILL;

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo with a simple busy model
// (transmitter busy for 10 cycles after each send strobe).
module tb_uart_line_echo;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       draining;
  logic [4:0] line_len;
  logic       overflow;

  int total = 0;
  int fails = 0;
  int busy_cnt;
  logic [7:0] q[$];

  uart_line_echo_if #(.PAYLOAD_BITS(8)) bus ();

  uart_line_echo #(
    .PAYLOAD_BITS(8),
    .DEPTH       (16),
    .TERM        (8'h0D)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .draining(draining),
    .line_len(line_len),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn)             busy_cnt <= 0;
    else if (bus.uart_tx_en) busy_cnt <= 10;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign bus.uart_tx_busy = busy_cnt != 0;

  always @(negedge clk) begin
    if (bus.uart_tx_en) q.push_back(bus.uart_tx_data);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = b;
    @(negedge clk);
    bus.uart_rx_valid = 1'b0;
  endtask

  task automatic do_break();
    @(negedge clk);
    bus.uart_rx_break = 1'b1;
    @(negedge clk);
    bus.uart_rx_break = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (draining && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, draining}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_en", {31'd0, bus.uart_tx_en}, 0);
    check("rst_tx_data", {24'd0, bus.uart_tx_data}, 0);
    check("rst_draining", {31'd0, draining}, 0);
    check("rst_line_len", {27'd0, line_len}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // "AB\r"
    q.delete();
    send(8'h41);
    send(8'h42);
    send(8'h0D);
    check("ab_draining", {31'd0, draining}, 1);
    check("ab_len_drain", {27'd0, line_len}, 3);
    @(negedge clk);
    check("ab_first_en", {31'd0, bus.uart_tx_en}, 1);
    wait_idle();
    check("ab_count", q.size(), 3);
    if (q.size() == 3) begin
      check("ab_b0", {24'd0, q[0]}, 32'h41);
      check("ab_b1", {24'd0, q[1]}, 32'h42);
      check("ab_b2", {24'd0, q[2]}, 32'h0D);
    end
    check("ab_ovf", {31'd0, overflow}, 0);
    check("ab_len_after", {27'd0, line_len}, 0);

    // lone terminator
    q.delete();
    send(8'h0D);
    check("lone_len", {27'd0, line_len}, 1);
    wait_idle();
    check("lone_count", q.size(), 1);
    if (q.size() == 1) check("lone_b0", {24'd0, q[0]}, 32'h0D);
    check("lone_len_after", {27'd0, line_len}, 0);

    // 15 bytes + terminator fills exactly
    q.delete();
    for (int i = 0; i < 15; i++) send(8'h33);
    send(8'h0D);
    check("fill_len", {27'd0, line_len}, 16);
    wait_idle();
    check("fill_count", q.size(), 16);
    if (q.size() == 16) begin
      check("fill_first", {24'd0, q[0]}, 32'h33);
      check("fill_last", {24'd0, q[15]}, 32'h0D);
    end
    check("fill_ovf", {31'd0, overflow}, 0);

    // break discards "XY"
    q.delete();
    send(8'h58);
    send(8'h59);
    do_break();
    check("brk_len", {27'd0, line_len}, 0);
    send(8'h5A);
    send(8'h0D);
    wait_idle();
    check("brk_count", q.size(), 2);
    if (q.size() == 2) begin
      check("brk_b0", {24'd0, q[0]}, 32'h5A);
      check("brk_b1", {24'd0, q[1]}, 32'h0D);
    end
    check("brk_ovf", {31'd0, overflow}, 0);

    // byte during drain is dropped
    q.delete();
    send(8'h51);
    send(8'h0D);
    send(8'h77);
    wait_idle();
    check("dd_count", q.size(), 2);
    if (q.size() == 2) begin
      check("dd_b0", {24'd0, q[0]}, 32'h51);
      check("dd_b1", {24'd0, q[1]}, 32'h0D);
    end
    check("dd_ovf", {31'd0, overflow}, 1);

    do_reset();
    check("rst2_ovf", {31'd0, overflow}, 0);

    // 17 bytes then terminator: overflow, terminator dropped
    q.delete();
    for (int i = 0; i < 17; i++) send(8'h55);
    check("ov_ovf_early", {31'd0, overflow}, 1);
    send(8'h0D);
    check("ov_draining", {31'd0, draining}, 1);
    check("ov_len", {27'd0, line_len}, 16);
    wait_idle();
    check("ov_count", q.size(), 16);
    n = 0;
    foreach (q[i]) if (q[i] == 8'h55) n++;
    check("ov_all55", n, 16);
    check("ov_ovf", {31'd0, overflow}, 1);

    // reset while a send strobe is high
    q.delete();
    send(8'h4D);
    send(8'h4E);
    send(8'h0D);
    n = 0;
    while (!bus.uart_tx_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_en_seen", {31'd0, bus.uart_tx_en}, 1);
    #1 resetn = 1'b0;
    #1;
    check("mid_tx_en", {31'd0, bus.uart_tx_en}, 0);
    check("mid_tx_data", {24'd0, bus.uart_tx_data}, 0);
    check("mid_draining", {31'd0, draining}, 0);
    check("mid_len", {27'd0, line_len}, 0);
    check("mid_ovf", {31'd0, overflow}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    q.delete();
    repeat (60) @(negedge clk);
    check("mid_quiet", q.size(), 0);

    // fresh line after reset
    send(8'h4B);
    send(8'h0D);
    wait_idle();
    check("post_count", q.size(), 2);
    if (q.size() == 2) begin
      check("post_b0", {24'd0, q[0]}, 32'h4B);
      check("post_b1", {24'd0, q[1]}, 32'h0D);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
